// File: rtl/des_round_key_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : des_round_key_gen_if
//  Description : Bundles the key-load handshake and the round-key stream of
//                des_round_key_gen.
//                master = key source / round-key consumer
//                slave  = key schedule
//  Signals     : key_valid/key_ready/key_in/decrypt  key-load handshake
//                rk_valid/rk_ready/rk_data/rk_index/rk_last  round-key stream
//                key_err  one-cycle pulse on a rejected key
//  Revision    : 1.0  initial release
// ============================================================================
interface des_round_key_gen_if;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key_in;
    logic        decrypt;
    logic        rk_valid;
    logic        rk_ready;
    logic [47:0] rk_data;
    logic [3:0]  rk_index;
    logic        rk_last;
    logic        key_err;

    modport master (
        output key_valid, key_in, decrypt, rk_ready,
        input  key_ready, rk_valid, rk_data, rk_index, rk_last, key_err
    );

    modport slave (
        input  key_valid, key_in, decrypt, rk_ready,
        output key_ready, rk_valid, rk_data, rk_index, rk_last, key_err
    );
endinterface
`default_nettype wire

// File: rtl/des_round_key_gen.sv
`default_nettype none
// ============================================================================
//  Module      : des_round_key_gen
//  Description : DES key schedule. Accepts a 64-bit key plus an encrypt/decrypt
//                flag and streams the 16 48-bit round keys, one per accepted
//                beat (K1..K16 for encrypt, K16..K1 for decrypt).
//  Ports       : clk    rising-edge clock
//                rst_n  synchronous active-low reset
//                bus    des_round_key_gen_if.slave (key load + round-key stream)
//  Parameters  : PARITY_CHECK  1 = reject keys whose bytes are not odd parity
//  Revision    : 1.0  initial release
// ============================================================================
module des_round_key_gen #(
    parameter int PARITY_CHECK = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    des_round_key_gen_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Permutation tables use DES 1-based bit numbers (bit 1 = MSB).
    localparam int c_pc1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int c_pc2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] f_pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55-i] = k[64-c_pc1[i]];
        end
        return r;
    endfunction

    function automatic logic [47:0] f_pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[47-i] = cd[56-c_pc2[i]];
        end
        return r;
    endfunction

    function automatic logic [27:0] f_rotl(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] f_rotr(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    state_t      state_q;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic        dec_q;
    logic [3:0]  idx_q;
    logic        err_q;

    logic [55:0] w_pc1;
    logic [3:0]  w_next_beat;
    logic        w_single;
    logic [27:0] c_step_d;
    logic [27:0] d_step_d;
    logic        w_parity_ok;

    // Rotation applied when moving to the next beat. Decrypt walks the
    // encrypt schedule backwards, so it undoes the shift of the round it
    // is leaving, which lands on the same beat numbers {1,8,15}.
    always_comb begin
        w_pc1       = f_pc1(bus.key_in);
        w_next_beat = idx_q + 4'd1;
        w_single    = (w_next_beat == 4'd1) || (w_next_beat == 4'd8) ||
                      (w_next_beat == 4'd15);
        c_step_d    = dec_q ? f_rotr(c_q, w_single) : f_rotl(c_q, w_single);
        d_step_d    = dec_q ? f_rotr(d_q, w_single) : f_rotl(d_q, w_single);
    end

    generate
        if (PARITY_CHECK != 0) begin : g_parity
            always_comb begin
                w_parity_ok = 1'b1;
                for (int b = 0; b < 8; b++) begin
                    w_parity_ok = w_parity_ok & (^bus.key_in[8*b +: 8]);
                end
            end
        end else begin : g_no_parity
            assign w_parity_ok = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            dec_q   <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.key_valid) begin
                        if (w_parity_ok) begin
                            // Decrypt starts at CD16, which equals CD0.
                            c_q     <= bus.decrypt ? w_pc1[55:28]
                                                   : f_rotl(w_pc1[55:28], 1'b1);
                            d_q     <= bus.decrypt ? w_pc1[27:0]
                                                   : f_rotl(w_pc1[27:0], 1'b1);
                            dec_q   <= bus.decrypt;
                            idx_q   <= '0;
                            state_q <= ST_RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.rk_ready) begin
                        if (idx_q == 4'd15) begin
                            idx_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q <= w_next_beat;
                            c_q   <= c_step_d;
                            d_q   <= d_step_d;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.key_ready = (state_q == ST_IDLE);
    assign bus.rk_valid  = (state_q == ST_RUN);
    assign bus.rk_data   = f_pc2({c_q, d_q});
    assign bus.rk_index  = idx_q;
    assign bus.rk_last   = (state_q == ST_RUN) && (idx_q == 4'd15);
    assign bus.key_err   = err_q;

endmodule
`default_nettype wire
